// File: rtl/cam_stream_gen.sv
// cam_stream_gen: OV7670-style camera stream generator.
// Produces v_sync / h_ref framing and an 8-bit byte stream with selectable
// test patterns. Runs a finite number of frames or runs continuously, and
// only stops at a frame boundary.
//
// Ports:
//   clk          byte clock, one camera byte per tick
//   reset        synchronous, active-high
//   enable_i     run request
//   mode_i       0 constant, 1 ramp, 2 RGB565 colour bars, 3 line^frame
//   const_i      byte value used by mode 0
//   frames_i     frames to emit, 0 = continuous
//   v_sync_o     frame sync (first V_SYNC_LINES lines)
//   h_ref_o      line valid
//   data_o       pixel byte (0 outside h_ref)
//   frame_done_o one-cycle pulse on the last byte of each frame
//   busy_o       high while frames are being emitted
//
// state | meaning
// IDLE  | outputs held at 0, waiting for enable_i, inputs latched on start
// RUN   | counters advance every clk, stop evaluated on the last frame byte
module cam_stream_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_TOTAL         = 784,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int V_SYNC_LINES    = 3,
    parameter int V_ACTIVE_START  = 20,
    parameter int V_ACTIVE        = 480,
    parameter int V_TOTAL         = 510
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic [1:0] mode_i,
    input  logic [7:0] const_i,
    input  logic [7:0] frames_i,
    output logic       v_sync_o,
    output logic       h_ref_o,
    output logic [7:0] data_o,
    output logic       frame_done_o,
    output logic       busy_o
);

    localparam int LINE_CLKS = H_TOTAL * BYTES_PER_PIXEL;
    localparam int ACT_CLKS  = H_ACTIVE * BYTES_PER_PIXEL;
    localparam int BAR_W     = H_ACTIVE / 8;
    localparam int CW        = $clog2(LINE_CLKS + 1);
    localparam int LW        = $clog2(V_TOTAL + 1);
    localparam int BW        = $clog2(BAR_W + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [LW-1:0]   line;
    logic            sub;        // byte index within the current pixel
    logic [7:0]      pix_x;      // only the low byte of pix_x is ever used
    logic [BW-1:0]   bar_px;     // pixel index within the current bar
    logic [2:0]      bar;
    logic [7:0]      frame_cnt;
    logic [1:0]      mode_lat;
    logic [7:0]      const_lat;
    logic [7:0]      frames_lat;

    logic            col_last;
    logic            line_last;
    logic            pix_last;
    logic            href_c;
    logic            vsync_c;
    logic            stop_c;
    logic [7:0]      line_rel;
    logic [15:0]     rgb;
    logic [7:0]      pat;

    always_comb begin
        col_last  = (col == CW'(LINE_CLKS - 1));
        line_last = (line == LW'(V_TOTAL - 1));
        pix_last  = (sub == 1'(BYTES_PER_PIXEL - 1));
        vsync_c   = (line < LW'(V_SYNC_LINES));
        href_c    = (line >= LW'(V_ACTIVE_START)) &&
                    (line < LW'(V_ACTIVE_START + V_ACTIVE)) &&
                    (col < CW'(ACT_CLKS));
        // Only meaningful inside the active window, where line >= V_ACTIVE_START.
        line_rel  = 8'(line - LW'(V_ACTIVE_START));
        stop_c    = !enable_i ||
                    ((frames_lat != 8'd0) && ((frame_cnt + 8'd1) == frames_lat));

        rgb = 16'h0000;
        case (bar)
            3'd0: rgb = 16'hFFFF;
            3'd1: rgb = 16'hFFE0;
            3'd2: rgb = 16'h07FF;
            3'd3: rgb = 16'h07E0;
            3'd4: rgb = 16'hF81F;
            3'd5: rgb = 16'hF800;
            3'd6: rgb = 16'h001F;
            default: rgb = 16'h0000;
        endcase

        pat = 8'h00;
        case (mode_lat)
            2'd0: pat = const_lat;
            2'd1: pat = pix_x;
            // with one byte per pixel only the high byte goes out
            2'd2: pat = (BYTES_PER_PIXEL == 1 || sub == 1'b0) ? rgb[15:8] : rgb[7:0];
            default: pat = line_rel ^ frame_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            col          <= '0;
            line         <= '0;
            sub          <= 1'b0;
            pix_x        <= 8'd0;
            bar_px       <= '0;
            bar          <= 3'd0;
            frame_cnt    <= 8'd0;
            mode_lat     <= 2'd0;
            const_lat    <= 8'd0;
            frames_lat   <= 8'd0;
            v_sync_o     <= 1'b0;
            h_ref_o      <= 1'b0;
            data_o       <= 8'd0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    v_sync_o     <= 1'b0;
                    h_ref_o      <= 1'b0;
                    data_o       <= 8'd0;
                    frame_done_o <= 1'b0;
                    busy_o       <= 1'b0;
                    col          <= '0;
                    line         <= '0;
                    sub          <= 1'b0;
                    pix_x        <= 8'd0;
                    bar_px       <= '0;
                    bar          <= 3'd0;
                    frame_cnt    <= 8'd0;
                    if (enable_i) begin
                        mode_lat   <= mode_i;
                        const_lat  <= const_i;
                        frames_lat <= frames_i;
                        state      <= RUN;
                    end
                end

                RUN: begin
                    v_sync_o     <= vsync_c;
                    h_ref_o      <= href_c;
                    data_o       <= href_c ? pat : 8'd0;
                    frame_done_o <= col_last && line_last;
                    busy_o       <= 1'b1;

                    if (col_last) begin
                        col    <= '0;
                        sub    <= 1'b0;
                        pix_x  <= 8'd0;
                        bar_px <= '0;
                        bar    <= 3'd0;
                        line   <= line_last ? '0 : line + LW'(1);
                    end else begin
                        col <= col + CW'(1);
                        if (pix_last) begin
                            sub   <= 1'b0;
                            pix_x <= pix_x + 8'd1;
                            if (bar_px == BW'(BAR_W - 1)) begin
                                bar_px <= '0;
                                bar    <= bar + 3'd1;
                            end else begin
                                bar_px <= bar_px + BW'(1);
                            end
                        end else begin
                            sub <= 1'b1;
                        end
                    end

                    if (col_last && line_last) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        if (stop_c) begin
                            state <= IDLE;
                        end else begin
                            mode_lat  <= mode_i;
                            const_lat <= const_i;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen with small frame geometry (20 clks/line,
// 120 clks/frame). An arithmetic reference model predicts every output
// cycle; directed scenarios add framing, pattern and timing checks.
module tb_cam_stream_gen;

    localparam int H_ACTIVE       = 8;
    localparam int H_TOTAL        = 10;
    localparam int BPP            = 2;
    localparam int V_SYNC_LINES   = 1;
    localparam int V_ACTIVE_START = 2;
    localparam int V_ACTIVE       = 3;
    localparam int V_TOTAL        = 6;
    localparam int LINE_CLKS      = H_TOTAL * BPP;
    localparam int FRAME_CLKS     = LINE_CLKS * V_TOTAL;

    logic       clk;
    logic       reset;
    logic       enable_i;
    logic [1:0] mode_i;
    logic [7:0] const_i;
    logic [7:0] frames_i;
    logic       v_sync_o;
    logic       h_ref_o;
    logic [7:0] data_o;
    logic       frame_done_o;
    logic       busy_o;

    cam_stream_gen #(
        .H_ACTIVE       (H_ACTIVE),
        .H_TOTAL        (H_TOTAL),
        .BYTES_PER_PIXEL(BPP),
        .V_SYNC_LINES   (V_SYNC_LINES),
        .V_ACTIVE_START (V_ACTIVE_START),
        .V_ACTIVE       (V_ACTIVE),
        .V_TOTAL        (V_TOTAL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable_i),
        .mode_i      (mode_i),
        .const_i     (const_i),
        .frames_i    (frames_i),
        .v_sync_o    (v_sync_o),
        .h_ref_o     (h_ref_o),
        .data_o      (data_o),
        .frame_done_o(frame_done_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // reference model
    logic [15:0] rgb_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    bit          m_run = 0;
    int          m_t   = 0;
    int          m_fc  = 0;
    logic [1:0]  m_mode = 0;
    logic [7:0]  m_const = 0;
    logic [7:0]  m_frames = 0;
    logic [11:0] m_exp = 0;

    task automatic model_step();
        int line, col, px, bsel, bar;
        logic vs, hr, last;
        logic [7:0] d;
        d = 8'h00;
        if (reset) begin
            m_run = 0;
            m_exp = '0;
        end else if (!m_run) begin
            m_exp = '0;
            if (enable_i) begin
                m_run = 1; m_t = 0; m_fc = 0;
                m_mode = mode_i; m_const = const_i; m_frames = frames_i;
            end
        end else begin
            line = m_t / LINE_CLKS;
            col  = m_t % LINE_CLKS;
            px   = col / BPP;
            bsel = col % BPP;
            vs   = (line < V_SYNC_LINES);
            hr   = (line >= V_ACTIVE_START) && (line < V_ACTIVE_START + V_ACTIVE) && (px < H_ACTIVE);
            if (hr) begin
                case (m_mode)
                    2'd0: d = m_const;
                    2'd1: d = px[7:0];
                    2'd2: begin
                        bar = px / (H_ACTIVE / 8);
                        d = (bsel == 0) ? rgb_tab[bar][15:8] : rgb_tab[bar][7:0];
                    end
                    default: d = 8'(line - V_ACTIVE_START) ^ 8'(m_fc);
                endcase
            end
            last  = (m_t == FRAME_CLKS - 1);
            m_exp = {vs, hr, d, last, 1'b1};
            if (last) begin
                m_fc++;
                m_t = 0;
                if (!enable_i || (m_frames != 0 && m_fc == int'(m_frames))) m_run = 0;
                else begin
                    m_mode = mode_i;
                    m_const = const_i;
                end
            end else begin
                m_t++;
            end
        end
    endtask

    // per-scenario observations
    int         cyc;
    int         n_vs;
    int         n_hr;
    int         first_vs;
    int         q_fd[$];
    logic [7:0] q_hr[$];
    logic [7:0] q_burst[$];
    logic       prev_hr;

    task automatic clear_stats();
        cyc = 0; n_vs = 0; n_hr = 0; first_vs = -1; prev_hr = 1'b0;
        q_fd.delete(); q_hr.delete(); q_burst.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk("outs", {20'd0, v_sync_o, h_ref_o, data_o, frame_done_o, busy_o}, {20'd0, m_exp});
        if (v_sync_o) begin
            n_vs++;
            if (first_vs < 0) first_vs = cyc;
        end
        if (h_ref_o) begin
            n_hr++;
            q_hr.push_back(data_o);
            if (!prev_hr) q_burst.push_back(data_o);
        end
        prev_hr = h_ref_o;
        if (frame_done_o) q_fd.push_back(cyc);
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((busy_o || k < 2) && k < max);
        chk("drain_done", 32'(k < max), 32'd1);
    endtask

    task automatic run_frames(input int n, input int max);
        int k;
        k = 0;
        while (q_fd.size() < n && k < max) begin
            tick();
            k++;
        end
        chk("fd_reached", 32'(q_fd.size() >= n), 32'd1);
    endtask

    logic [7:0] bars_exp [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                  8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
    logic [7:0] burst_exp [6] = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h00, 8'h03};

    initial begin
        int bad;
        logic [7:0] cst;

        reset = 1'b1; enable_i = 1'b0; mode_i = 2'd0; const_i = 8'd0; frames_i = 8'd0;
        clear_stats();
        repeat (3) tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_vsync", 32'(v_sync_o), 32'd0);
        reset = 1'b0;
        tick();

        // single constant frame
        clear_stats();
        frames_i = 8'd1; const_i = 8'hA5; mode_i = 2'd0; enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        drain(400);
        chk("s1_vs_len", n_vs, 20);
        chk("s1_hr_len", n_hr, 48);
        chk("s1_bursts", q_burst.size(), 3);
        chk("s1_fd_n", q_fd.size(), 1);
        if (q_fd.size() > 0) chk("s1_fd_at", q_fd[0] - first_vs, 119);
        bad = 0;
        foreach (q_hr[i]) if (q_hr[i] !== 8'hA5) bad++;
        chk("s1_data", bad, 0);
        chk("s1_busy_end", 32'(busy_o), 32'd0);

        // colour bars
        clear_stats();
        frames_i = 8'd1; mode_i = 2'd2; enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        drain(400);
        chk("s2_hr_n", q_hr.size(), 48);
        for (int i = 0; i < 16 && i < q_hr.size(); i++) chk("s2_bar", q_hr[i], bars_exp[i]);

        // continuous run, late disable
        clear_stats();
        frames_i = 8'd0; mode_i = 2'd3; enable_i = 1'b1;
        repeat (150) tick();
        enable_i = 1'b0;
        drain(400);
        chk("s3_fd_n", q_fd.size(), 2);
        if (q_fd.size() == 2) begin
            chk("s3_fd_last", q_fd[1] - first_vs, 239);
            chk("s3_fd_gap", q_fd[1] - q_fd[0], 120);
        end
        chk("s3_bursts", q_burst.size(), 6);
        for (int i = 0; i < 6 && i < q_burst.size(); i++) chk("s3_burst", q_burst[i], burst_exp[i]);

        // finite count with mid-frame mode change
        clear_stats();
        cst = 8'($urandom_range(1, 255));
        frames_i = 8'd3; const_i = cst; mode_i = 2'd0; enable_i = 1'b1;
        repeat (60) tick();
        mode_i = 2'd1;
        run_frames(3, 500);
        enable_i = 1'b0;
        tick();
        chk("s4_busy_end", 32'(busy_o), 32'd0);
        chk("s4_fd_n", q_fd.size(), 3);
        if (q_fd.size() == 3) begin
            chk("s4_gap1", q_fd[1] - q_fd[0], 120);
            chk("s4_gap2", q_fd[2] - q_fd[1], 120);
        end
        if (q_hr.size() >= 64) begin
            chk("s4_const", q_hr[47], cst);
            for (int i = 0; i < 16; i++) chk("s4_ramp", q_hr[48 + i], 32'(i / 2));
        end else chk("s4_hr_n", q_hr.size(), 144);

        // reset mid-frame with enable held
        clear_stats();
        frames_i = 8'd0; mode_i = 2'd1; enable_i = 1'b1;
        repeat (51) tick();
        reset = 1'b1;
        tick();
        chk("s5_rst_outs", {27'd0, v_sync_o, h_ref_o, frame_done_o, busy_o, |data_o}, 32'd0);
        reset = 1'b0;
        tick();
        chk("s5_start_idle", 32'(v_sync_o), 32'd0);
        tick();
        chk("s5_vsync", 32'(v_sync_o), 32'd1);
        chk("s5_busy", 32'(busy_o), 32'd1);
        repeat (30) tick();
        enable_i = 1'b0;
        drain(400);

        // back-to-back restart
        clear_stats();
        frames_i = 8'd1; mode_i = 2'd0; const_i = 8'h3C; enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        run_frames(1, 200);
        enable_i = 1'b1;
        tick();
        chk("s6_gap_busy", 32'(busy_o), 32'd0);
        chk("s6_gap_vsync", 32'(v_sync_o), 32'd0);
        enable_i = 1'b0;
        tick();
        chk("s6_new_vsync", 32'(v_sync_o), 32'd1);
        drain(400);

        // randomized stimulus against the model
        for (int r = 0; r < 12; r++) begin
            clear_stats();
            frames_i = 8'($urandom_range(0, 2));
            mode_i   = 2'($urandom);
            const_i  = 8'($urandom);
            enable_i = 1'b1;
            repeat (250) begin
                if ($urandom_range(0, 29) == 0) mode_i = 2'($urandom);
                if ($urandom_range(0, 29) == 0) const_i = 8'($urandom);
                if ($urandom_range(0, 39) == 0) frames_i = 8'($urandom_range(0, 3));
                if ($urandom_range(0, 49) == 0) enable_i = ~enable_i;
                reset = ($urandom_range(0, 299) == 0);
                tick();
            end
            reset = 1'b0;
            enable_i = 1'b0;
            drain(400);
            chk("rnd_idle", 32'(busy_o), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_stream_gen.md
# cam_stream_gen

Synthesizable, parametrised OV7670-style camera stream generator that drives `v_sync`, `h_ref` and an 8-bit byte stream with selectable test patterns. It replaces hand-written bench timing for camera-path regression. It also serves as an on-chip camera substitute, feeding the capture path (`v_sync_i`/`h_sync_i`/`cam_data_i`) when no sensor is fitted. It generates finite or continuous frame sequences with a clean stop at frame boundaries.

## Interface
Parameters:
- `H_ACTIVE`, 640, active pixels per line; must be divisible by 8.
- `H_TOTAL`, 784, total pixel periods per line; must be greater than `H_ACTIVE`.
- `BYTES_PER_PIXEL`, 2, bytes per pixel; 1 or 2. One byte is emitted per `clk`.
- `V_SYNC_LINES`, 3, number of lines with `v_sync` high at frame start.
- `V_ACTIVE_START`, 20, first line with `h_ref`; must be greater than `V_SYNC_LINES`.
- `V_ACTIVE`, 480, number of active lines.
- `V_TOTAL`, 510, total lines per frame; must satisfy `V_ACTIVE_START + V_ACTIVE <= V_TOTAL`.

Ports:
- `clk` in 1: byte clock. One tick equals one camera byte period.
- `reset` in 1: synchronous, active-high.
- `enable_i` in 1: run request.
- `mode_i` in 2: pattern select. 0 = constant, 1 = ramp, 2 = colour bars, 3 = line^frame.
- `const_i` in 8: byte value for mode 0.
- `frames_i` in 8: number of frames to emit. 0 = continuous.
- `v_sync_o` out 1: frame sync.
- `h_ref_o` out 1: line valid.
- `data_o` out 8: pixel byte.
- `frame_done_o` out 1: one-cycle pulse on the last byte of each frame.
- `busy_o` out 1: high while frames are being emitted.

## Operation
- Derived constants:
  - `LINE_CLKS = H_TOTAL*BYTES_PER_PIXEL`.
  - `FRAME_CLKS = LINE_CLKS*V_TOTAL`.
- Counters:
  - `col` runs 0..`LINE_CLKS`-1 and wraps to 0; on wrap, `line` increments.
  - `line` runs 0..`V_TOTAL`-1 and wraps to 0 at end of frame.
  - `frame_cnt` is 8 bits and wraps.
  - `pix_x = col / BYTES_PER_PIXEL`. Implement as a sub-counter; no divider.
- States:
  - IDLE:
    - All outputs 0.
    - When `enable_i`=1, latch `mode_i`, `const_i` and `frames_i`; clear `col`, `line` and the emitted-frame count; go to RUN.
  - RUN:
    - Counters advance every `clk`.
    - At the last byte of a frame (`line`=`V_TOTAL`-1, `col`=`LINE_CLKS`-1), evaluate the stop condition.
    - Stop when `enable_i`=0, or when latched frames≠0 and this was the latched-frames-th frame. On stop, go to IDLE.
    - Otherwise, re-latch `mode_i`/`const_i` and continue with `line`=0 (no gap between frames).
- `enable_i` deasserting mid-frame never truncates a frame. The current frame completes.
- `mode_i`/`const_i` changes mid-frame are ignored until the next frame boundary.
- `v_sync` = (`line` < `V_SYNC_LINES`).
- `h_ref` = (`V_ACTIVE_START` ≤ `line` < `V_ACTIVE_START+V_ACTIVE`) and (`col` < `H_ACTIVE*BYTES_PER_PIXEL`).
- `data_o` is 0 whenever `h_ref_o`=0. When `h_ref_o`=1:
  - Mode 0: `const`.
  - Mode 1: `pix_x[7:0]`. The same value is repeated for every byte of the pixel.
  - Mode 2: RGB565 bars, `bar` = `pix_x` / (`H_ACTIVE`/8), 0..7.
    - Bar colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
    - High byte first.
    - If `BYTES_PER_PIXEL`=1, only the high byte is sent.
  - Mode 3: (`line` − `V_ACTIVE_START`)[7:0] XOR `frame_cnt`.
- `frame_cnt` starts at 0 on the RUN entry and increments at each frame boundary.

## Timing
- All outputs are registered. The values for counter position (`line`,`col`) appear on the outputs one cycle after the counters hold that position.
- Start: `enable_i` sampled 1 in IDLE at edge k. At edge k+1 the outputs show `line`0/`col`0: `v_sync_o`=1, `busy_o`=1.
- `frame_done_o`=1 in the same output cycle as the last byte of a frame. It is never asserted in IDLE.
- Stop: the cycle after the final `frame_done_o`, all outputs read 0 and `busy_o`=0.
- Re-enabling in that same cycle starts a new run with one IDLE cycle gap. The new run re-latches `frames_i`.
- Reset:
  - Applies at the next edge and overrides everything, including mid-frame.
  - All outputs 0, state IDLE, all counters 0.
  - Reset with `enable_i`=1 starts a run on the first edge after reset deasserts.
- Frame period is exactly `FRAME_CLKS` clocks; consecutive frames are back-to-back.

## Test plan
All scenarios use small parameters: `H_ACTIVE`=8, `H_TOTAL`=10, `BYTES_PER_PIXEL`=2, `V_SYNC_LINES`=1, `V_ACTIVE_START`=2, `V_ACTIVE`=3, `V_TOTAL`=6. This gives `LINE_CLKS`=20 and `FRAME_CLKS`=120.

- **Basic single frame, mode 0:** `frames_i`=1, `const_i`=A5, enable for 1 cycle.
  - `v_sync_o` high for 20 cycles.
  - `h_ref_o` high in 3 bursts of 16 cycles with period 20; `data_o`=A5 in every burst.
  - Exactly one `frame_done_o`, 119 cycles after the first `v_sync_o`; `busy_o` then drops.
- **Colour bars:** mode 2, `frames_i`=1.
  - Each active line reads FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
- **Continuous run with late disable:** `frames_i`=0, enable held, mode 3.
  - Line bursts read 00,01,02 in frame 0 and 01,00,03 in frame 1.
  - Drop enable at cycle 150: the stream ends after cycle 240 (second `frame_done_o`), not earlier.
- **Finite count and mode latching:** `frames_i`=3, `mode_i` switched 0→1 mid frame 0.
  - Frame 0 stays constant.
  - Frames 1–2 show ramp 00 00 01 01 … 07 07.
  - Exactly 3 `frame_done_o` pulses, 120 cycles apart.
- **Reset mid-operation:** assert `reset` at cycle 50 of frame 0.
  - Next edge: all outputs 0, `busy_o`=0.
  - With `enable_i` held 1, `v_sync_o` re-asserts 1 cycle after `reset` deasserts, and frame timing restarts from line 0.
- **Back-to-back restart:** after a `frames_i`=1 run, raise enable in the `busy_o`-falling cycle.
  - Exactly one idle cycle, then a new `v_sync_o`.
